// File: rtl/mfcc_fft_pkg.sv
// Shared definitions for the MFCC FFT launch path: state encodings, FFT size
// limits and the log2 N -> run-parameter derivation.
package mfcc_fft_pkg;

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_RUN     = 3'd3,
    ST_DELIVER = 3'd4
  } fft_state_e;

  localparam logic [3:0] LOG2N_MIN = 4'd4;
  localparam logic [3:0] LOG2N_MAX = 4'd11;
  localparam logic [3:0] LOG2N_RST = 4'd9;

  function automatic logic [3:0] clamp_log2n(input logic [3:0] v);
    if (v < LOG2N_MIN) return LOG2N_MIN;
    if (v > LOG2N_MAX) return LOG2N_MAX;
    return v;
  endfunction

  // N - 1
  function automatic logic [31:0] calc_max_point(input logic [3:0] log2n);
    return (32'd1 << log2n) - 32'd1;
  endfunction

  // N/2 + lat - 1: butterfly count per stage plus pipeline fill
  function automatic logic [15:0] calc_core_count(input logic [3:0] log2n,
                                                  input int unsigned lat);
    logic [31:0] t;
    t = ((32'd1 << log2n) >> 1) + lat - 32'd1;
    return t[15:0];
  endfunction

endpackage

// File: rtl/fft_cfg_regs.sv
// FFT size configuration: clamped shadow register, active register loaded
// only when the launch FSM allows it, and registered derived run parameters.
module fft_cfg_regs
  import mfcc_fft_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int CORE_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            cfg_log2_n,
  input  logic                  cfg_apply,
  input  logic                  load_en,
  output logic                  cfg_busy,
  output logic [ADDR_WIDTH-1:0] max_point_fft,
  output logic [15:0]           max_point_fft_core,
  output logic [3:0]            stage_number
);

  localparam logic [ADDR_WIDTH-1:0] RST_MAX  = ADDR_WIDTH'(calc_max_point(LOG2N_RST));
  localparam logic [15:0]           RST_CORE = calc_core_count(LOG2N_RST, CORE_LATENCY);

  logic [3:0]            shadow_q;
  logic [3:0]            active_q;
  logic                  pending_q;
  logic                  upd_q;
  logic [ADDR_WIDTH-1:0] max_w;

  assign max_w = ADDR_WIDTH'(calc_max_point(active_q));

  // Launch is held off while a load is pending or its derived outputs are
  // still one cycle behind the active register.
  assign cfg_busy = pending_q | upd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q           <= LOG2N_RST;
      active_q           <= LOG2N_RST;
      pending_q          <= 1'b0;
      upd_q              <= 1'b0;
      max_point_fft      <= RST_MAX;
      max_point_fft_core <= RST_CORE;
      stage_number       <= LOG2N_RST;
    end else begin
      upd_q <= 1'b0;
      if (load_en && pending_q) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
        upd_q     <= 1'b1;
      end
      if (cfg_apply) begin
        shadow_q  <= clamp_log2n(cfg_log2_n);
        pending_q <= 1'b1;
      end
      max_point_fft      <= max_w;
      max_point_fft_core <= calc_core_count(active_q, CORE_LATENCY);
      stage_number       <= active_q;
    end
  end

endmodule

// File: rtl/fft_launch_ctrl.sv
// FFT run initiator: launches one run per ready frame, supervises it with a
// timeout and delivers the result over valid/ready. FFT_FRAME_CNT_EN enables frame_count.
module fft_launch_ctrl
  import mfcc_fft_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int CORE_LATENCY   = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            cfg_log2_n,
  input  logic                  cfg_apply,
  input  logic                  frame_valid,
  output logic                  frame_ack,
  output logic                  ena_fft,
  input  logic                  end_fft,
  output logic [ADDR_WIDTH-1:0] max_point_fft,
  output logic [15:0]           max_point_fft_core,
  output logic [3:0]            stage_number,
  output logic                  fft_busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  err_timeout,
  input  logic                  err_clr,
  output logic [15:0]           frame_count,
  output logic [2:0]            dbg_state
);

  // Handshake: res_valid rises on entry to DELIVER and stays high until the
  // cycle res_ready is sampled high; that cycle is the single accept.

  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  fft_state_e               state_q;
  logic                     st_cnt_q;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q;
  logic                     cfg_busy;

  assign dbg_state = state_q;

  fft_cfg_regs #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .CORE_LATENCY (CORE_LATENCY)
  ) u_cfg (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_log2_n         (cfg_log2_n),
    .cfg_apply          (cfg_apply),
    .load_en            (state_q == ST_IDLE),
    .cfg_busy           (cfg_busy),
    .max_point_fft      (max_point_fft),
    .max_point_fft_core (max_point_fft_core),
    .stage_number       (stage_number)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_STARTUP;
      st_cnt_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      ena_fft     <= 1'b0;
      frame_ack   <= 1'b0;
      fft_busy    <= 1'b0;
      res_valid   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ena_fft   <= 1'b0;
      frame_ack <= 1'b0;
      if (err_clr) err_timeout <= 1'b0;
      case (state_q)
        ST_STARTUP: begin
          // Two cycles mirror the network controller's RESET->INITIAL step.
          st_cnt_q <= 1'b1;
          if (st_cnt_q) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (frame_valid && !cfg_busy) begin
            state_q   <= ST_LAUNCH;
            ena_fft   <= 1'b1;
            frame_ack <= 1'b1;
            fft_busy  <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          tmo_cnt_q <= '0;
          state_q   <= ST_RUN;
        end
        ST_RUN: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          if (end_fft) begin
            state_q   <= ST_DELIVER;
            fft_busy  <= 1'b0;
            res_valid <= 1'b1;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q     <= ST_IDLE;
            fft_busy    <= 1'b0;
            err_timeout <= 1'b1;
          end
        end
        ST_DELIVER: begin
          if (res_ready) begin
            state_q   <= ST_IDLE;
            res_valid <= 1'b0;
          end
        end
        default: state_q <= ST_STARTUP;
      endcase
    end
  end

`ifdef FFT_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else if (res_valid && res_ready) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_fft_launch_ctrl.sv
// Directed bench for fft_launch_ctrl: reset, config clamping and deferral,
// result handshake, timeout supervision and mid-run reset.
module tb_fft_launch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cfg_log2_n;
  logic        cfg_apply;
  logic        frame_valid;
  logic        frame_ack;
  logic        ena_fft;
  logic        end_fft;
  logic [11:0] max_point_fft;
  logic [15:0] max_point_fft_core;
  logic [3:0]  stage_number;
  logic        fft_busy;
  logic        res_valid;
  logic        res_ready;
  logic        err_timeout;
  logic        err_clr;
  logic [15:0] frame_count;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

`ifdef FFT_FRAME_CNT_EN
  localparam int FC_EN = 1;
`else
  localparam int FC_EN = 0;
`endif

  localparam logic [31:0] S_STARTUP = 0, S_IDLE = 1, S_LAUNCH = 2, S_RUN = 3, S_DELIVER = 4;

  always #5 clk = ~clk;

  fft_launch_ctrl #(
    .ADDR_WIDTH     (12),
    .CORE_LATENCY   (4),
    .TIMEOUT_CYCLES (100),
    .TIMEOUT_WIDTH  (16)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_log2_n         (cfg_log2_n),
    .cfg_apply          (cfg_apply),
    .frame_valid        (frame_valid),
    .frame_ack          (frame_ack),
    .ena_fft            (ena_fft),
    .end_fft            (end_fft),
    .max_point_fft      (max_point_fft),
    .max_point_fft_core (max_point_fft_core),
    .stage_number       (stage_number),
    .fft_busy           (fft_busy),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .err_timeout        (err_timeout),
    .err_clr            (err_clr),
    .frame_count        (frame_count),
    .dbg_state          (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_params(input string tag, input int m, input int c, input int s);
    check({tag, "_max"},   32'(max_point_fft),      32'(m));
    check({tag, "_core"},  32'(max_point_fft_core), 32'(c));
    check({tag, "_stage"}, 32'(stage_number),       32'(s));
  endtask

  task automatic wait_ena(input string tag, output int n);
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      tick;
      if (ena_fft === 1'b1) begin
        n = i;
        break;
      end
    end
    check({tag, "_seen"}, 32'(n != 0), 32'd1);
  endtask

  task automatic apply_cfg(input logic [3:0] v);
    cfg_log2_n = v;
    cfg_apply  = 1'b1;
    tick;
    cfg_apply  = 1'b0;
    tick;
    tick;
  endtask

  task automatic accept;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
  endtask

  initial begin
    int n;
    int vc;
    int pulses;
    int first;
    logic [3:0] stage_before;

    rst_n = 1'b0; cfg_log2_n = 4'd0; cfg_apply = 1'b0; frame_valid = 1'b1;
    end_fft = 1'b0; res_ready = 1'b0; err_clr = 1'b0;

    // Reset state
    tick; tick;
    check("rst_ena", 32'(ena_fft), 0);
    check("rst_ack", 32'(frame_ack), 0);
    check("rst_busy", 32'(fft_busy), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_err", 32'(err_timeout), 0);
    check("rst_fc", 32'(frame_count), 0);
    check("rst_state", 32'(dbg_state), S_STARTUP);
    check_params("rst", 511, 259, 9);

    // First launch after startup
    rst_n = 1'b1;
    wait_ena("first", n);
    check("launch_ge3", 32'(n >= 3), 1);
    check("launch_lat", 32'(n), 3);
    check("launch_ack", 32'(frame_ack), 1);
    check("launch_busy", 32'(fft_busy), 1);
    check("launch_state", 32'(dbg_state), S_LAUNCH);
    check_params("launch", 511, 259, 9);
    frame_valid = 1'b0;
    tick;
    check("ena_single", 32'(ena_fft), 0);
    check("run_state", 32'(dbg_state), S_RUN);
    tick; tick;
    end_fft = 1'b1; tick; end_fft = 1'b0;
    check("deliver_valid", 32'(res_valid), 1);
    check("deliver_state", 32'(dbg_state), S_DELIVER);
    check("deliver_busy", 32'(fft_busy), 0);

    // res_ready low for 5 cycles, accepted on the 6th
    vc = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid === 1'b1) vc++;
      tick;
    end
    res_ready = 1'b1;
    if (res_valid === 1'b1) vc++;
    tick;
    res_ready = 1'b0;
    check("valid_cycles", 32'(vc), 6);
    check("valid_drop", 32'(res_valid), 0);
    check("idle_after_accept", 32'(dbg_state), S_IDLE);
    check("fc_1", 32'(frame_count), 32'(FC_EN));

    // end_fft outside RUN is ignored
    end_fft = 1'b1; tick; end_fft = 1'b0; tick;
    check("stray_end_valid", 32'(res_valid), 0);
    check("stray_end_state", 32'(dbg_state), S_IDLE);

    // Config in IDLE, with clamping
    apply_cfg(4'd11);
    check_params("cfg11", 2047, 1027, 11);
    apply_cfg(4'd2);
    check_params("cfg2", 15, 11, 4);
    apply_cfg(4'd12);
    check_params("cfg12", 2047, 1027, 11);

    // Config applied during RUN is deferred to IDLE
    frame_valid = 1'b1;
    wait_ena("defer", n);
    frame_valid = 1'b0;
    tick;
    cfg_log2_n = 4'd6; cfg_apply = 1'b1; tick; cfg_apply = 1'b0; tick;
    check_params("hold_run", 2047, 1027, 11);
    end_fft = 1'b1; tick; end_fft = 1'b0;
    check_params("hold_deliver", 2047, 1027, 11);
    accept;
    check("hold_idle_stage", 32'(stage_number), 11);
    frame_valid = 1'b1;
    n = 0;
    stage_before = 4'd0;
    for (int i = 1; i <= 20; i++) begin
      stage_before = stage_number;
      tick;
      if (ena_fft === 1'b1) begin
        n = i;
        break;
      end
    end
    check("defer_launch_seen", 32'(n != 0), 1);
    check("cfg6_before_launch", 32'(stage_before), 6);
    check_params("cfg6", 63, 35, 6);
    frame_valid = 1'b0;
    tick;
    end_fft = 1'b1; tick; end_fft = 1'b0;
    accept;
    check("fc_2", 32'(frame_count), 32'(2 * FC_EN));

    // Timeout at RUN cycle 100
    frame_valid = 1'b1;
    wait_ena("tmo", n);
    frame_valid = 1'b0;
    tick;
    for (int i = 0; i < 99; i++) tick;
    check("tmo_not_yet", 32'(err_timeout), 0);
    check("tmo_still_run", 32'(dbg_state), S_RUN);
    tick;
    check("tmo_set", 32'(err_timeout), 1);
    check("tmo_idle", 32'(dbg_state), S_IDLE);
    check("tmo_no_result", 32'(res_valid), 0);
    check("tmo_busy", 32'(fft_busy), 0);
    err_clr = 1'b1; tick; err_clr = 1'b0;
    check("tmo_clr", 32'(err_timeout), 0);

    // end_fft on cycle 100 wins over the timeout
    frame_valid = 1'b1;
    wait_ena("race", n);
    frame_valid = 1'b0;
    tick;
    for (int i = 0; i < 99; i++) tick;
    end_fft = 1'b1; tick; end_fft = 1'b0;
    check("race_no_err", 32'(err_timeout), 0);
    check("race_deliver", 32'(dbg_state), S_DELIVER);
    check("race_valid", 32'(res_valid), 1);
    accept;
    check("fc_3", 32'(frame_count), 32'(3 * FC_EN));

    // Timeout set beats a simultaneous err_clr
    frame_valid = 1'b1;
    wait_ena("setclr", n);
    frame_valid = 1'b0;
    tick;
    for (int i = 0; i < 99; i++) tick;
    err_clr = 1'b1; tick; err_clr = 1'b0;
    check("set_beats_clr", 32'(err_timeout), 1);

    // Reset mid-run
    frame_valid = 1'b1;
    wait_ena("midrst", n);
    tick; tick;
    rst_n = 1'b0;
    #1;
    check("mr_state", 32'(dbg_state), S_STARTUP);
    check("mr_busy", 32'(fft_busy), 0);
    check("mr_ack", 32'(frame_ack), 0);
    check("mr_valid", 32'(res_valid), 0);
    check("mr_err", 32'(err_timeout), 0);
    check("mr_fc", 32'(frame_count), 0);
    check_params("mr", 511, 259, 9);
    tick;
    rst_n = 1'b1;
    pulses = 0;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      tick;
      if (ena_fft === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("mr_pulses", 32'(pulses), 1);
    check("mr_first", 32'(first), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
